// File: rtl/arith_unit_seq.sv
`timescale 1ns/1ps
// arith_unit_seq: registered WIDTH-bit arithmetic unit behind a valid/ready
// handshake. It returns a result plus NZVC flags and keeps a carry register
// (cst) so that ADC/SBC can chain multi-word arithmetic.
//
// Build option ARITH_MUL_EN: when defined, opcode 110 runs a WIDTH-cycle
// shift-add multiply. When undefined, no multiplier is built and opcode 110
// completes in one cycle with op_err set.
//
// Handshake: a request is accepted on a rising edge where in_valid && in_ready,
// capturing A, B and sel. A result is consumed on a rising edge where
// out_valid && out_ready. result/NZVC/op_err hold while out_valid && !out_ready.
// in_ready is combinational from state and out_ready only.
module arith_unit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       NZVC,
  output logic             op_err,
  output logic [1:0]       dbg_state
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_INC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_ADC = 3'b100;
  localparam logic [2:0] OP_SBC = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ARITH_MUL_EN
    S_MUL  = 2'd1,
`endif
    S_HOLD = 2'd2
  } state_t;

  state_t state;
  logic   cst;
  logic   accept;

  assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // Single-cycle datapath: every add/sub-type op is A + b_eff + cin.
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic             inv_c;
  logic [WIDTH:0]   sum;
  logic             c_msb_in;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_nzvc;

  // Select the effective B operand and carry-in for the requested opcode.
  always_comb begin
    b_eff = B;
    cin   = 1'b0;
    inv_c = 1'b0;
    case (sel)
      OP_ADD: begin
        b_eff = B;
      end
      OP_INC: begin
        b_eff = '0;
        cin   = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        b_eff = ~B;
        cin   = 1'b1;
        inv_c = 1'b1;
      end
      OP_DEC: begin
        // A + all-ones is A - 1; carry out is the inverted borrow.
        b_eff = '1;
        inv_c = 1'b1;
      end
      OP_ADC: begin
        cin = cst;
      end
      OP_SBC: begin
        b_eff = ~B;
        cin   = ~cst;
        inv_c = 1'b1;
      end
      default: begin
        b_eff = B;
      end
    endcase
    sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    c_msb_in = A[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
    alu_res  = (sel == OP_CMP) ? A : sum[WIDTH-1:0];
    alu_nzvc = {sum[WIDTH-1], (sum[WIDTH-1:0] == '0), c_msb_in ^ sum[WIDTH], sum[WIDTH] ^ inv_c};
  end

`ifdef ARITH_MUL_EN
  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [CW-1:0]      mul_cnt;
  logic [2*WIDTH-1:0] mul_acc_nxt;
  logic               mul_hi_nz;

  // One shift-add step: add the shifted multiplicand when the current B bit is set.
  assign mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_hi_nz   = |mul_acc_nxt[2*WIDTH-1:WIDTH];
`endif

  // Control FSM with registered result, flags and carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      NZVC      <= 4'b0000;
      op_err    <= 1'b0;
      cst       <= 1'b0;
`ifdef ARITH_MUL_EN
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
`endif
    end else begin
      // Result consumed: go idle unless a new request overrides below.
      if ((state == S_HOLD) && out_ready) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
      end

`ifdef ARITH_MUL_EN
      if (state == S_MUL) begin
        mul_acc    <= mul_acc_nxt;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt + 1'b1;
        if (mul_cnt == CNT_LAST) begin
          state     <= S_HOLD;
          out_valid <= 1'b1;
          result    <= mul_acc_nxt[WIDTH-1:0];
          NZVC      <= {mul_acc_nxt[WIDTH-1], (mul_acc_nxt[WIDTH-1:0] == '0), mul_hi_nz, mul_hi_nz};
          op_err    <= 1'b0;
          cst       <= mul_hi_nz;
        end
      end
`endif

      if (accept) begin
        if (sel == OP_MUL) begin
`ifdef ARITH_MUL_EN
          state      <= S_MUL;
          out_valid  <= 1'b0;
          mul_acc    <= '0;
          mul_mcand  <= {{WIDTH{1'b0}}, A};
          mul_mplier <= B;
          mul_cnt    <= '0;
`else
          // Unsupported opcode: flag the error, leave cst untouched.
          state     <= S_HOLD;
          out_valid <= 1'b1;
          result    <= '0;
          NZVC      <= 4'b0100;
          op_err    <= 1'b1;
`endif
        end else begin
          state     <= S_HOLD;
          out_valid <= 1'b1;
          result    <= alu_res;
          NZVC      <= alu_nzvc;
          op_err    <= 1'b0;
          cst       <= alu_nzvc[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
`timescale 1ns/1ps
// Bench for arith_unit_seq: directed scenarios plus randomized traffic, with
// every consumed result compared against an arithmetic reference model.
module tb_arith_unit_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic [2:0]   sel = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [3:0]   NZVC;
  logic         op_err;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  bit rand_sink = 1'b0;

  logic [W+4:0] exp_q[$];
  logic         m_cst = 1'b0;

  arith_unit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(opa), .B(opb), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .NZVC(NZVC), .op_err(op_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {op_err, N, Z, V, C, result} from plain integer arithmetic.
  function automatic logic [W+4:0] model(input logic [2:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic c,
                                         output logic c_next);
    longint mod_v = longint'(1) << W;
    longint half  = longint'(1) << (W - 1);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint ci = c ? 1 : 0;
    longint sa = (ua >= half) ? ua - mod_v : ua;
    longint sb = (ub >= half) ? ub - mod_v : ub;
    longint r  = 0;
    longint sr = 0;
    logic [W-1:0] res;
    logic n, z, v, cf, err;
    cf = 1'b0;
    err = 1'b0;
    case (s)
      3'b000: begin r = ua + ub;      sr = sa + sb;      cf = (r >= mod_v); end
      3'b001: begin r = ua + 1;       sr = sa + 1;       cf = (r >= mod_v); end
      3'b010: begin r = ua - ub;      sr = sa - sb;      cf = (ua < ub); end
      3'b011: begin r = ua - 1;       sr = sa - 1;       cf = (ua < 1); end
      3'b100: begin r = ua + ub + ci; sr = sa + sb + ci; cf = (r >= mod_v); end
      3'b101: begin r = ua - ub - ci; sr = sa - sb - ci; cf = (ua < ub + ci); end
      3'b111: begin r = ua - ub;      sr = sa - sb;      cf = (ua < ub); end
      default: begin r = ua * ub; sr = 0; end
    endcase
    res = r[W-1:0];
    n = res[W-1];
    z = (res == '0);
    v = (sr > half - 1) || (sr < -half);
    c_next = cf;
    if (s == 3'b110) begin
`ifdef ARITH_MUL_EN
      cf = ((r / mod_v) != 0);
      v  = cf;
      c_next = cf;
`else
      res = '0; n = 1'b0; z = 1'b1; v = 1'b0; cf = 1'b0; err = 1'b1;
      c_next = c;
`endif
    end
    if (s == 3'b111) return {err, n, z, v, cf, a};
    return {err, n, z, v, cf, res};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic         prev_hold = 1'b0;
  logic [W+4:0] prev_val = '0;

  always @(negedge clk) begin
    logic [W+4:0] e;
    logic cn;
    if (rst) begin
      exp_q.delete();
      m_cst = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && out_valid)
        check("hold_stable", {op_err, NZVC, result}, prev_val);
      prev_hold = out_valid && !out_ready;
      prev_val  = {op_err, NZVC, result};
      if (out_valid && out_ready) begin
        check("sb_has_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_result", result, e[W-1:0]);
          check("sb_nzvc", NZVC, e[W+3:W]);
          check("sb_op_err", op_err, e[W+4]);
        end
      end
      if (in_valid && in_ready) begin
        e = model(sel, opa, opb, m_cst, cn);
        m_cst = cn;
        exp_q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_sink) begin
      #2;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks (start and end 2ns after a rising edge) ----------------
  task automatic send(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit rel);
    int n;
    n = 0;
    in_valid = 1'b1;
    sel = s;
    opa = a;
    opb = b;
    if (rel) out_ready = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("accept_in_bound", (n < 64), 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic [W-1:0] r, output logic [3:0] f,
                             output logic e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) check("in_ready_busy", in_ready, 0);
    end while (!out_valid && lat < 64);
    r = result;
    f = NZVC;
    e = op_err;
    @(posedge clk);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [W-1:0] r;
    logic [3:0] f;
    logic e;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_nzvc", NZVC, 4'b0000);
    check("rst_op_err", op_err, 0);
    @(posedge clk);
    #2;

    // Overflowing add
    send(3'b000, 8'h7F, 8'h01, 1'b0);
    wait_result(lat, r, f, e);
    check("add_lat", lat, 1);
    check("add_res", r, 8'h80);
    check("add_nzvc", f, 4'b1010);

    // Borrowing subtract, then compare of equal values
    send(3'b010, 8'h00, 8'h01, 1'b0);
    wait_result(lat, r, f, e);
    check("sub_res", r, 8'hFF);
    check("sub_nzvc", f, 4'b1001);
    send(3'b111, 8'h05, 8'h05, 1'b0);
    wait_result(lat, r, f, e);
    check("cmp_res", r, 8'h05);
    check("cmp_nzvc", f, 4'b0100);

    // Carry chain: ADC issued in the cycle the ADD result is presented
    send(3'b000, 8'hFF, 8'h01, 1'b0);
    send(3'b100, 8'h00, 8'h00, 1'b0);
    wait_result(lat, r, f, e);
    check("adc_chain_lat", lat, 1);
    check("adc_chain_res", r, 8'h01);
    check("adc_chain_nzvc", f, 4'b0000);

    // Opcode 110
`ifdef ARITH_MUL_EN
    send(3'b110, 8'h10, 8'h10, 1'b0);
    wait_result(lat, r, f, e);
    check("mul1_lat", lat, W + 1);
    check("mul1_res", r, 8'h00);
    check("mul1_nzvc", f, 4'b0111);
    send(3'b110, 8'h0F, 8'h0F, 1'b0);
    wait_result(lat, r, f, e);
    check("mul2_res", r, 8'hE1);
    check("mul2_nzvc", f, 4'b1000);
    check("mul2_err", e, 0);
`else
    send(3'b110, 8'h10, 8'h10, 1'b0);
    wait_result(lat, r, f, e);
    check("op6_lat", lat, 1);
    check("op6_res", r, 8'h00);
    check("op6_nzvc", f, 4'b0100);
    check("op6_err", e, 1);
`endif

    // Backpressure: result holds, in_ready low, then release with a new request
    out_ready = 1'b0;
    send(3'b001, 8'h41, 8'h00, 1'b0);
    wait_result(lat, r, f, e);
    check("inc_res", r, 8'h42);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_result", result, 8'h42);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #2;
    end
    send(3'b000, 8'h03, 8'h04, 1'b1);
    wait_result(lat, r, f, e);
    check("b2b_lat", lat, 1);
    check("b2b_res", r, 8'h07);

    // Reset in the middle of opcode 110; cst set beforehand must be cleared
    send(3'b000, 8'hFF, 8'h01, 1'b0);
    wait_result(lat, r, f, e);
    check("pre_rst_carry", f[0], 1);
    send(3'b110, 8'h10, 8'h10, 1'b0);
    cycles(3);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_nzvc", NZVC, 4'b0000);
    check("abort_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    send(3'b100, 8'h01, 8'h01, 1'b0);
    wait_result(lat, r, f, e);
    check("post_rst_adc_res", r, 8'h02);
    check("post_rst_adc_nzvc", f, 4'b0000);

    // Randomized traffic with random consumer backpressure
    rand_sink = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'b0);
      cycles($urandom_range(0, 2));
    end
    rand_sink = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    cycles(W + 5);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
